// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode-stage register file / scoreboard:
//   - default geometry (XLEN, NREG, RIDX, NWB, PCW)
//   - instruction field positions and a packed view of the instruction word
//   - count_hits(): number of valid writeback ports targeting one index
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 16;
    localparam int RIDX_DEF = 4;
    localparam int NWB_DEF  = 2;
    localparam int PCW_DEF  = 2;

    // Upper bounds used to give count_hits() a fixed signature; callers pad
    // their narrower writeback vectors with zeros.
    localparam int MAX_NWB  = 8;
    localparam int MAX_RIDX = 8;
    localparam int HCW      = $clog2(MAX_NWB + 1);

    // Instruction field positions.
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 25;
    localparam int IMMF_BIT = 24;
    localparam int RD_MSB   = 23;
    localparam int RD_LSB   = 20;
    localparam int RS_MSB   = 19;
    localparam int RS_LSB   = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef struct packed {
        logic [6:0]  opcode;
        logic        immf;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
    } id_instr_t;

    // Count the writeback ports that are valid and aim at register idx.
    function automatic logic [HCW-1:0] count_hits(
        input logic [MAX_NWB-1:0]                wb_v,
        input logic [MAX_NWB-1:0][MAX_RIDX-1:0]  wb_r,
        input logic [MAX_RIDX-1:0]               idx
    );
        logic [HCW-1:0] n;
        n = '0;
        for (int k = 0; k < MAX_NWB; k++) begin
            if (wb_v[k] && (wb_r[k] == idx)) n = n + HCW'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/id_sb_counter.sv
// ---------------------------------------------------------------------------
// id_sb_counter
// One pending-write counter of the scoreboard.
//   clk, rst  : clock, asynchronous active-low reset
//   flush_i   : clear to 0 (beats inc/dec)
//   inc_i     : +1 (a reservation accepted this cycle)
//   dec_i     : -n (writeback hits this cycle), floor at 0
//   cnt_o     : current count
// ---------------------------------------------------------------------------
module id_sb_counter
    import id_pkg::*;
#(
    parameter int PCW = PCW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           inc_i,
    input  logic [HCW-1:0] dec_i,
    output logic [PCW-1:0] cnt_o
);

    // One extra bit so cnt+inc never wraps before the comparisons.
    localparam int W = ((PCW > HCW) ? PCW : HCW) + 1;
    localparam logic [W-1:0] MAX_W = W'((1 << PCW) - 1);

    logic [PCW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   up_w, dn_w;

    assign up_w = W'(cnt_q) + W'(inc_i);
    assign dn_w = W'(dec_i);

    // NOTE: every path of a combinational block assigns its outputs, so no latch is inferred.
    always_comb begin
        if (flush_i) begin
            cnt_d = '0;
        end else if (dn_w >= up_w) begin
            cnt_d = '0;                 // unreserved writebacks floor at zero
        end else if ((up_w - dn_w) > MAX_W) begin
            cnt_d = '1;
        end else begin
            cnt_d = PCW'(up_w - dn_w);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_regfile_sb.sv
// ---------------------------------------------------------------------------
// id_regfile_sb
// Decode-stage register file with per-register pending-write scoreboard.
//   clk, rst       : clock, asynchronous active-low reset
//   issue_i        : decoded instruction valid
//   rd_idx_i       : destination / first source index (always read)
//   rs_idx_i       : second source index, read when rs_used_i
//   reserve_i      : instruction will write rd; bump pend[rd] on accept
//   stall_i        : downstream stall; outputs hold, nothing accepted
//   wb_i/wb_r_i/wb_data_i : NWB writeback ports, higher port wins on conflict
//   flush_i        : clear every pending counter
//   rd_value_o, rs_value_o, valid_o : registered operands (latency 1)
//   stall_o        : combinational, issue cannot be taken this cycle
//   pend_o         : per-register "has outstanding writes" flags
// ---------------------------------------------------------------------------
module id_regfile_sb
    import id_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int RIDX    = RIDX_DEF,
    parameter int NWB     = NWB_DEF,
    parameter int PCW     = PCW_DEF,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_i,
    input  logic [RIDX-1:0]     rd_idx_i,
    input  logic [RIDX-1:0]     rs_idx_i,
    input  logic                rs_used_i,
    input  logic                reserve_i,
    input  logic                stall_i,
    input  logic [NWB-1:0]      wb_i,
    input  logic [NWB*RIDX-1:0] wb_r_i,
    input  logic [NWB*XLEN-1:0] wb_data_i,
    input  logic                flush_i,
    output logic [XLEN-1:0]     rd_value_o,
    output logic [XLEN-1:0]     rs_value_o,
    output logic                valid_o,
    output logic                stall_o,
    output logic [NREG-1:0]     pend_o
);

    localparam int CW = ((PCW > HCW) ? PCW : HCW) + 1;
    localparam logic [CW-1:0] PEND_MAX = CW'((1 << PCW) - 1);

    logic [XLEN-1:0] regs_q  [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [PCW-1:0]  cnt     [NREG];
    logic [HCW-1:0]  hits    [NREG];
    logic [NREG-1:0] wr_en, inc, blocked, full;

    logic [MAX_NWB-1:0]               wb_v_pad;
    logic [MAX_NWB-1:0][MAX_RIDX-1:0] wb_r_pad;

    logic            accept;
    logic [XLEN-1:0] rd_value_q, rs_value_q;
    logic            valid_q;

    // Widen the writeback ports to the fixed shape count_hits() expects.
    always_comb begin
        wb_v_pad = '0;
        wb_r_pad = '0;
        for (int k = 0; k < NWB; k++) begin
            wb_v_pad[k] = wb_i[k];
            wb_r_pad[k] = MAX_RIDX'(wb_r_i[k*RIDX +: RIDX]);
        end
    end

    // Per-register writeback merge, bypass value and hazard flags.
    always_comb begin
        for (int x = 0; x < NREG; x++) begin
            hits[x]    = count_hits(wb_v_pad, wb_r_pad, MAX_RIDX'(x));
            wr_en[x]   = (hits[x] != '0);
            wr_data[x] = regs_q[x];
            // Ascending scan: the highest port targeting x ends up winning.
            for (int k = 0; k < NWB; k++) begin
                if (wb_i[k] && (wb_r_i[k*RIDX +: RIDX] == RIDX'(x))) begin
                    wr_data[x] = wb_data_i[k*XLEN +: XLEN];
                end
            end
            if (ZERO_R0 && (x == 0)) begin
                wr_en[x]   = 1'b0;
                wr_data[x] = '0;
            end
            // wr_data doubles as the bypassed read value.
            blocked[x] = CW'(cnt[x]) > CW'(hits[x]);
            // pend - hits == max, rearranged so nothing underflows.
            full[x]    = CW'(cnt[x]) == (PEND_MAX + CW'(hits[x]));
            pend_o[x]  = (cnt[x] != '0);
        end
    end

    assign stall_o = stall_i
                   | (issue_i & (blocked[rd_idx_i]
                               | (rs_used_i & blocked[rs_idx_i])
                               | (reserve_i & full[rd_idx_i])));
    assign accept  = issue_i & ~stall_o;

    always_comb begin
        for (int x = 0; x < NREG; x++) begin
            inc[x] = accept && reserve_i && (rd_idx_i == RIDX'(x))
                     && !(ZERO_R0 && (x == 0));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        id_sb_counter #(.PCW(PCW)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush_i),
            .inc_i   (inc[g]),
            .dec_i   (hits[g]),
            .cnt_o   (cnt[g])
        );
    end

    // NOTE: the register array is reset because reads after reset must return 0; this keeps it out of RAM macros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < NREG; x++) regs_q[x] <= '0;
        end else begin
            for (int x = 0; x < NREG; x++) begin
                if (wr_en[x]) regs_q[x] <= wr_data[x];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_value_q <= '0;
            rs_value_q <= '0;
            valid_q    <= 1'b0;
        end else if (accept) begin
            rd_value_q <= wr_data[rd_idx_i];
            rs_value_q <= rs_used_i ? wr_data[rs_idx_i] : '0;
            valid_q    <= 1'b1;
        end else if (!stall_i) begin
            valid_q    <= 1'b0;
        end
    end

    assign rd_value_o = rd_value_q;
    assign rs_value_o = rs_value_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_id_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_id_regfile_sb
// Directed scenarios followed by random traffic. The driver evaluates a
// behavioural model each cycle (plain arrays of register values and pending
// counts), checks stall_o/pend_o, and pushes expected operands into a queue;
// a separate monitor pops and compares whenever valid_o shows a new result.
// ---------------------------------------------------------------------------
module tb_id_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int RIDX = 4;
    localparam int NWB  = 2;
    localparam int PCW  = 2;
    localparam int PMAX = (1 << PCW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_i, rs_used_i, reserve_i, stall_i, flush_i;
    logic [RIDX-1:0]     rd_idx_i, rs_idx_i;
    logic [NWB-1:0]      wb_i;
    logic [NWB*RIDX-1:0] wb_r_i;
    logic [NWB*XLEN-1:0] wb_data_i;
    logic [XLEN-1:0]     rd_value_o, rs_value_o;
    logic                valid_o, stall_o;
    logic [NREG-1:0]     pend_o;

    id_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .RIDX(RIDX), .NWB(NWB), .PCW(PCW), .ZERO_R0(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (issue_i),
        .rd_idx_i   (rd_idx_i),
        .rs_idx_i   (rs_idx_i),
        .rs_used_i  (rs_used_i),
        .reserve_i  (reserve_i),
        .stall_i    (stall_i),
        .wb_i       (wb_i),
        .wb_r_i     (wb_r_i),
        .wb_data_i  (wb_data_i),
        .flush_i    (flush_i),
        .rd_value_o (rd_value_o),
        .rs_value_o (rs_value_o),
        .valid_o    (valid_o),
        .stall_o    (stall_o),
        .pend_o     (pend_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] rs;
    } exp_t;

    exp_t            sb_q[$];
    logic [XLEN-1:0] m_reg  [NREG];
    int              m_pend [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < NREG; x++) begin
            m_reg[x]  = '0;
            m_pend[x] = 0;
        end
        sb_q.delete();
    endtask

    task automatic set_idle();
        issue_i   = 1'b0;
        rs_used_i = 1'b0;
        reserve_i = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        rd_idx_i  = '0;
        rs_idx_i  = '0;
        wb_i      = '0;
        wb_r_i    = '0;
        wb_data_i = '0;
    endtask

    task automatic set_wb(input int k, input int idx, input logic [XLEN-1:0] data);
        wb_i[k]                 = 1'b1;
        wb_r_i[k*RIDX +: RIDX]  = RIDX'(idx);
        wb_data_i[k*XLEN +: XLEN] = data;
    endtask

    task automatic set_issue(input int rd, input int rs, input bit used, input bit res);
        issue_i   = 1'b1;
        rd_idx_i  = RIDX'(rd);
        rs_idx_i  = RIDX'(rs);
        rs_used_i = used;
        reserve_i = res;
    endtask

    // Evaluate the current inputs against the model at the falling edge,
    // advance the model across the next rising edge, return at posedge+1.
    task automatic tick();
        int              hits [NREG];
        logic [XLEN-1:0] val  [NREG];
        bit              we   [NREG];
        logic [NREG-1:0] exp_pend;
        bit              rd_blk, rs_blk, ovf, exp_stall, acc;
        int              rd, rs, idx, p;
        exp_t            e;
        @(negedge clk);
        for (int x = 0; x < NREG; x++) begin
            hits[x] = 0;
            we[x]   = 1'b0;
            val[x]  = m_reg[x];
            exp_pend[x] = (m_pend[x] != 0);
        end
        for (int k = 0; k < NWB; k++) begin
            if (wb_i[k]) begin
                idx = int'(wb_r_i[k*RIDX +: RIDX]);
                hits[idx]++;
                we[idx]  = 1'b1;
                val[idx] = wb_data_i[k*XLEN +: XLEN];
            end
        end
        check("pend_o", 64'(pend_o), 64'(exp_pend));
        rd        = int'(rd_idx_i);
        rs        = int'(rs_idx_i);
        rd_blk    = (m_pend[rd] - hits[rd]) > 0;
        rs_blk    = rs_used_i && ((m_pend[rs] - hits[rs]) > 0);
        ovf       = reserve_i && ((m_pend[rd] - hits[rd]) == PMAX);
        exp_stall = stall_i || (issue_i && (rd_blk || rs_blk || ovf));
        check("stall_o", 64'(stall_o), 64'(exp_stall));
        acc = issue_i && !exp_stall;
        if (acc) begin
            e.rd = val[rd];
            e.rs = rs_used_i ? val[rs] : '0;
            sb_q.push_back(e);
        end
        for (int x = 0; x < NREG; x++) begin
            if (we[x]) m_reg[x] = val[x];
            if (flush_i) begin
                m_pend[x] = 0;
            end else begin
                p = m_pend[x] + ((acc && reserve_i && rd == x) ? 1 : 0) - hits[x];
                if (p < 0) p = 0;
                if (p > PMAX) p = PMAX;
                m_pend[x] = p;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a fresh result is valid_o high after an edge without stall_i.
    initial begin
        bit   stall_prev;
        exp_t e;
        stall_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && valid_o && !stall_prev) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 64'(valid_o), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_value_o", 64'(rd_value_o), 64'(e.rd));
                    check("rs_value_o", 64'(rs_value_o), 64'(e.rs));
                end
            end
            stall_prev = stall_i;
        end
    end

    initial begin
        rst = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_value", 64'(rd_value_o), 64'd0);
        check("reset_rs_value", 64'(rs_value_o), 64'd0);
        check("reset_valid",    64'(valid_o),    64'd0);
        check("reset_pend",     64'(pend_o),     64'd0);
        stall_i = 1'b1;
        #1 check("reset_stall_hi", 64'(stall_o), 64'd1);
        stall_i = 1'b0;
        #1 check("reset_stall_lo", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: preload r1/r2 through port 0, then read both.
        set_idle(); set_wb(0, 1, 32'h1); tick();
        set_idle(); set_wb(0, 2, 32'h2); tick();
        set_idle(); set_issue(1, 2, 1'b1, 1'b0); tick();
        set_idle(); tick();

        // 2: reserve r3, read it until port 1 writes 0xDEAD (bypassed).
        set_idle(); set_issue(3, 0, 1'b0, 1'b1); tick();
        set_idle(); set_issue(0, 3, 1'b1, 1'b0); tick(); tick(); tick();
        set_wb(1, 3, 32'hDEAD); tick();
        set_idle(); tick();

        // 3: repeated reservations of r5, then one alongside a writeback.
        for (int i = 0; i < 4; i++) begin
            set_idle(); set_issue(5, 0, 1'b0, 1'b1); tick();
        end
        set_wb(0, 5, 32'h55); tick();
        set_idle(); set_wb(1, 5, 32'h56); tick();
        set_idle(); tick();

        // 4: both ports write r4 in one cycle; the higher port wins.
        set_idle(); set_wb(0, 4, 32'h11); set_wb(1, 4, 32'h22); tick();
        set_idle(); set_issue(4, 4, 1'b1, 1'b0); tick();
        set_idle(); tick();

        // 5: reserve r6 and r7, flush alongside a new r6 reservation, then read.
        set_idle(); set_issue(6, 0, 1'b0, 1'b1); tick();
        set_idle(); set_issue(7, 0, 1'b0, 1'b1); tick();
        set_idle(); set_issue(6, 0, 1'b0, 1'b1); flush_i = 1'b1; tick();
        set_idle(); set_issue(6, 7, 1'b1, 1'b0); tick();
        set_idle(); tick();

        // 6: asynchronous reset while stalled with a pending reservation.
        set_idle(); set_issue(9, 0, 1'b0, 1'b1); tick();
        set_idle(); set_issue(9, 9, 1'b1, 1'b0); stall_i = 1'b1; tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_rd_value", 64'(rd_value_o), 64'd0);
        check("midrst_rs_value", 64'(rs_value_o), 64'd0);
        check("midrst_valid",    64'(valid_o),    64'd0);
        check("midrst_pend",     64'(pend_o),     64'd0);
        check("midrst_stall_hi", 64'(stall_o),    64'(stall_i));
        stall_i = 1'b0;
        #1 check("midrst_stall_lo", 64'(stall_o), 64'(stall_i));
        model_reset();
        set_idle();
        @(posedge clk);
        #1 rst = 1'b1;

        // Random traffic over a narrow index range so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            issue_i   = ($urandom_range(0, 9) < 7);
            rd_idx_i  = RIDX'($urandom_range(0, 7));
            rs_idx_i  = RIDX'($urandom_range(0, 7));
            rs_used_i = 1'($urandom_range(0, 1));
            reserve_i = 1'($urandom_range(0, 1));
            stall_i   = ($urandom_range(0, 9) == 0);
            flush_i   = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NWB; k++) begin
                wb_i[k]                   = ($urandom_range(0, 9) < 4);
                wb_r_i[k*RIDX +: RIDX]    = RIDX'($urandom_range(0, 7));
                wb_data_i[k*XLEN +: XLEN] = $urandom;
            end
            tick();
        end

        set_idle();
        repeat (3) tick();
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
